// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// approx_mul_pkg -- shared constants and types for the approximate-multiplier
// accumulation stage.                                       Revision: 1.0
// ============================================================================
package approx_mul_pkg;

  localparam int PROD_W = 16;
  localparam int CNT_W  = 9;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_add_u.sv
`default_nettype none
// ============================================================================
// sat_add_u -- unsigned W-bit + 16-bit saturating adder (combinational).
//                                                           Revision: 1.0
// ============================================================================
module sat_add_u
  import approx_mul_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]      i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [W-1:0]      o_sum,
  output logic              o_sat
);

  logic [W:0] w_full;

  // One extra bit catches the carry-out that triggers clamping.
  assign w_full = {1'b0, i_a} + {{(W + 1 - PROD_W){1'b0}}, i_b};
  assign o_sat  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule
`default_nettype wire

// File: rtl/approx_prod_accum.sv
`default_nettype none
// ============================================================================
// approx_prod_accum -- sums fixed-length runs of 16-bit products into a
// saturating accumulator and hands out one result per run. Revision: 1.0
// ============================================================================
module approx_prod_accum
  import approx_mul_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_accept;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sat;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_run_end;
  logic [ACC_W-1:0]   w_fin_sum;
  logic [CNT_W-1:0]   w_fin_cnt;
  logic               w_fin_ovf;

  sat_add_u #(
    .W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (in_prod),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  assign in_ready  = (r_state == ACCUM) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // A flush with nothing accumulated and nothing arriving produces no result.
  assign w_run_end = (w_accept && (w_cnt_inc == CNT_W'(LEN)))
                   || (flush && ((r_cnt != '0) || w_accept));

  assign w_fin_sum = w_accept ? w_sum : r_acc;
  assign w_fin_cnt = w_accept ? w_cnt_inc : r_cnt;
  assign w_fin_ovf = r_ovf | (w_accept & w_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_run_end) begin
            out_sum   <= w_fin_sum;
            out_count <= w_fin_cnt;
            out_ovf   <= w_fin_ovf;
            out_valid <= 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_state   <= HOLD;
          end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= w_fin_ovf;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
